flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit.sv | 109 ++++++++++
 tb/tb_flag_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Condition-flag unit: stages ALU flag updates and commits them one cycle later.
// Optional FLAG_FWD_EN forwards the staged flags to the branch unit while pending.
module flag_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_vld,
    input  logic [3:0]  alu_op,
    input  logic [15:0] alu_res,
    input  logic        alu_ovfl,
    input  logic        flush,
    input  logic        br_req,
    output logic        br_ack,
    output logic [2:0]  F,
    output logic        pending
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] f_q;
    logic [2:0] f_d;
    logic [2:0] stage_q;
    logic [2:0] stage_d;
    logic [2:0] base;
    logic [2:0] merged;
    logic       op_full;
    logic       op_zonly;
    logic       flag_set;
    logic       z_new;

    always_comb begin
        op_full  = 1'b0;
        op_zonly = 1'b0;
        case (alu_op)
            4'b0000, 4'b0001: op_full = 1'b1;
            4'b0010, 4'b0100,
            4'b0101, 4'b0110: op_zonly = 1'b1;
            default: ;
        endcase
    end

    assign flag_set = alu_vld & (op_full | op_zonly);
    assign z_new    = (alu_res == 16'h0000);

    // Retained V/N come from the newest value: the stage if one is held.
    assign base   = (state_q == PEND) ? stage_q : f_q;
    assign merged = op_full ? {z_new, alu_ovfl, alu_res[15]}
                            : {z_new, base[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= 3'b000;
            stage_q <= 3'b000;
        end else begin
            f_q     <= f_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        f_d     = f_q;
        if (flush) begin
            state_d = IDLE;
            stage_d = 3'b000;
        end else begin
            if (state_q == PEND) begin
                f_d = stage_q;
            end
            if (flag_set) begin
                state_d = PEND;
                stage_d = merged;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        pending = (state_q == PEND);
        br_ack  = 1'b0;
        F       = f_q;
        if (rst_n && br_req && !flag_set) begin
            br_ack = (state_q == IDLE);
        end
`ifdef FLAG_FWD_EN
        if (state_q == PEND) begin
            F = stage_q;
            if (rst_n && br_req && !flag_set) begin
                br_ack = 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: per-cycle vector table plus reset corners.
// Expectations cover both FLAG_FWD_EN builds.
module tb_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_vld;
    logic [3:0]  alu_op;
    logic [15:0] alu_res;
    logic        alu_ovfl;
    logic        flush;
    logic        br_req;
    logic        br_ack;
    logic [2:0]  F;
    logic        pending;

`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int NV = 21;

    typedef struct {
        logic        vld;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic        fl;
        logic        br;
        logic [2:0]  f_nf;
        logic        ack_nf;
        logic [2:0]  f_fw;
        logic        ack_fw;
        logic        pend;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  f;
        logic        ack;
        logic        pend;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    int   checks;
    int   errors;

    flag_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_vld  (alu_vld),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .alu_ovfl (alu_ovfl),
        .flush    (flush),
        .br_req   (br_req),
        .br_ack   (br_ack),
        .F        (F),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act,
                         input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic row(input int i, input logic vld, input logic [3:0] op,
                       input logic [15:0] res, input logic ovfl,
                       input logic fl, input logic br,
                       input logic [2:0] f_nf, input logic ack_nf,
                       input logic [2:0] f_fw, input logic ack_fw,
                       input logic pend);
        vecs[i] = '{vld, op, res, ovfl, fl, br,
                    f_nf, ack_nf, f_fw, ack_fw, pend};
    endtask

    task automatic drive(input logic vld, input logic [3:0] op,
                         input logic [15:0] res, input logic ovfl,
                         input logic fl, input logic br);
        alu_vld  = vld;
        alu_op   = op;
        alu_res  = res;
        alu_ovfl = ovfl;
        flush    = fl;
        br_req   = br;
    endtask

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        //   i vld op     res       ov fl br  F_nf  a  F_fw  a  pend
        row( 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b000, 1, 3'b000, 1, 0);
        row( 1, 1, 4'h0, 16'h0000, 1, 0, 0, 3'b000, 0, 3'b000, 0, 0);
        row( 2, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b000, 0, 3'b110, 0, 1);
        row( 3, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b110, 0, 3'b110, 0, 0);
        row( 4, 1, 4'h0, 16'h8000, 0, 0, 0, 3'b110, 0, 3'b110, 0, 0);
        row( 5, 1, 4'h2, 16'h0001, 0, 0, 0, 3'b110, 0, 3'b001, 0, 1);
        row( 6, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b001, 0, 3'b001, 0, 1);
        row( 7, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b001, 0, 3'b001, 0, 0);
        row( 8, 1, 4'h1, 16'h0000, 0, 0, 0, 3'b001, 0, 3'b001, 0, 0);
        row( 9, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b001, 0, 3'b100, 1, 1);
        row(10, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b100, 1, 3'b100, 1, 0);
        row(11, 1, 4'h0, 16'h8000, 1, 0, 0, 3'b100, 0, 3'b100, 0, 0);
        row(12, 1, 4'h0, 16'h0000, 0, 1, 0, 3'b100, 0, 3'b011, 0, 1);
        row(13, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b100, 0, 3'b100, 0, 0);
        row(14, 1, 4'h0, 16'h0001, 0, 0, 1, 3'b100, 0, 3'b100, 0, 0);
        row(15, 1, 4'h7, 16'h0000, 0, 0, 1, 3'b100, 0, 3'b000, 1, 1);
        row(16, 1, 4'h7, 16'h0000, 0, 0, 1, 3'b000, 1, 3'b000, 1, 0);
        row(17, 1, 4'h3, 16'h0000, 0, 0, 1, 3'b000, 1, 3'b000, 1, 0);
        row(18, 1, 4'h6, 16'h0000, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
        row(19, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b000, 0, 3'b100, 0, 1);
        row(20, 0, 4'h0, 16'h0000, 0, 0, 0, 3'b100, 0, 3'b100, 0, 0);

        #12;
        check("rst_F", F, 3'b000);
        check("rst_pending", {2'b00, pending}, 3'b000);
        check("rst_ack", {2'b00, br_ack}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].vld, vecs[i].op, vecs[i].res, vecs[i].ovfl,
                  vecs[i].fl, vecs[i].br);
            e.idx  = i;
            e.f    = FWD ? vecs[i].f_fw : vecs[i].f_nf;
            e.ack  = FWD ? vecs[i].ack_fw : vecs[i].ack_nf;
            e.pend = vecs[i].pend;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d_F", e.idx), F, e.f);
            check($sformatf("v%0d_ack", e.idx), {2'b00, br_ack},
                  {2'b00, e.ack});
            check($sformatf("v%0d_pend", e.idx), {2'b00, pending},
                  {2'b00, e.pend});
        end

        // Build stage 3'b111, then reset asynchronously mid-PEND.
        @(posedge clk);
        #1 drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 4'h2, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("pre_rst_pend", {2'b00, pending}, 3'b001);
        check("pre_rst_F", F, FWD ? 3'b111 : 3'b011);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_F", F, 3'b000);
        check("mid_rst_pend", {2'b00, pending}, 3'b000);
        check("mid_rst_ack", {2'b00, br_ack}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ack", {2'b00, br_ack}, 3'b001);
        @(posedge clk);
        #1;
        check("post_rst_F", F, 3'b000);
        check("post_rst_pend", {2'b00, pending}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
